// File: rtl/ifu_fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// FSM state codes and the default reset PC.
package ifu_fetch_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

  // Select codes driven by the downstream next-PC selector; anything other
  // than IFU_SEL_NORM arrives here as a redirect.
  typedef enum logic [1:0] {
    IFU_SEL_NORM = 2'd0,
    IFU_SEL_BR   = 2'd1,
    IFU_SEL_JMP  = 2'd2,
    IFU_SEL_EXC  = 2'd3
  } ifu_sel_e;

  typedef enum logic [1:0] {
    IFU_ST_FETCH = 2'd0,
    IFU_ST_WAIT  = 2'd1,
    IFU_ST_HOLD  = 2'd2,
    IFU_ST_DROP  = 2'd3
  } ifu_state_e;

  function automatic logic [31:0] ifu_pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory handshake and the
// decode-side valid/ready output.
interface ifu_fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst, out_adel
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst, out_adel
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one memory request at a time
// and presents {pc, instruction} to decode until accepted or redirected.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input logic   clk,
  input logic   reset,
  ifu_fetch_if.master bus
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        adel_q, adel_d;
  logic        aligned;
  logic        req;

  assign aligned = (pc_q[1:0] == 2'b00);
  assign req     = (state_q == IFU_ST_FETCH) && aligned && !reset;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    adel_d  = adel_q;

    if (bus.redirect) begin
      // A redirect never touches the presented word; out_valid drops because
      // the next state is never HOLD. DROP absorbs a response still in flight.
      pc_d = bus.redirect_pc;
      unique case (state_q)
        IFU_ST_FETCH: state_d = (req && bus.imem_gnt) ? IFU_ST_DROP : IFU_ST_FETCH;
        IFU_ST_WAIT:  state_d = bus.imem_rvalid ? IFU_ST_FETCH : IFU_ST_DROP;
        IFU_ST_HOLD:  state_d = IFU_ST_FETCH;
        IFU_ST_DROP:  state_d = bus.imem_rvalid ? IFU_ST_FETCH : IFU_ST_DROP;
        default:      state_d = IFU_ST_FETCH;
      endcase
    end else begin
      unique case (state_q)
        IFU_ST_FETCH: begin
          if (!aligned) begin
            inst_d  = '0;
            adel_d  = 1'b1;
            state_d = IFU_ST_HOLD;
          end else if (bus.imem_gnt) begin
            state_d = IFU_ST_WAIT;
          end
        end
        IFU_ST_WAIT: begin
          if (bus.imem_rvalid) begin
            inst_d  = bus.imem_rdata;
            adel_d  = 1'b0;
            state_d = IFU_ST_HOLD;
          end
        end
        IFU_ST_HOLD: begin
          if (bus.out_ready) begin
            pc_d    = ifu_pc_plus4(pc_q);
            state_d = IFU_ST_FETCH;
          end
        end
        IFU_ST_DROP: begin
          if (bus.imem_rvalid) state_d = IFU_ST_FETCH;
        end
        default: state_d = IFU_ST_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IFU_ST_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      adel_q  <= adel_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (state_q == IFU_ST_HOLD);
  assign bus.out_pc    = pc_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_adel  = adel_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage: owns the architectural PC register and fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake.
- Hands {pc, instruction} to decode over a valid/ready interface.
- The next-PC selector sits downstream. It takes out_pc, computes the target, and drives redirect/redirect_pc back into this block whenever its select is not IFU_SEL_NORM.
- Sequential PC+4 is generated internally.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded by reset.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- redirect  in  1  load redirect_pc as the new fetch PC, discarding the current fetch
- redirect_pc  in  32  target from the next-PC selector
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (always the current pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; exactly one per granted request, at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts this cycle
- out_pc  out  32  PC of the presented instruction
- out_inst  out  32  instruction word (0 when out_adel=1)
- out_adel  out  1  address-error on fetch (pc[1:0] != 0)

Behaviour:
- Reset, checked synchronously on a clock edge:
  - pc=RESET_PC, state=FETCH
  - out_valid=0, out_inst=0, out_adel=0, out_pc=RESET_PC
  - imem_req=0 while reset is high
- At most one outstanding memory request.
- States:
  - FETCH: imem_req=1 and imem_addr=pc when pc[1:0]==0.
    - If pc[1:0]!=0: no request is issued. Load out_inst=0, out_adel=1, then go to HOLD.
    - On imem_gnt: go to WAIT.
    - imem_addr is held stable while req=1 and gnt=0, unless a redirect occurs.
  - WAIT: imem_req=0. On imem_rvalid: capture imem_rdata into out_inst, set out_adel=0, go to HOLD.
  - HOLD: out_valid=1, with out_pc=pc and out_inst stable.
    - On out_ready: pc <= pc+4, go to FETCH.
    - out_valid drops the cycle after acceptance.
  - DROP: a stale request is in flight. imem_req=0, out_valid=0. On imem_rvalid: discard data, go to FETCH.
- Latency: with gnt in the same cycle and rvalid one cycle later, out_valid rises 2 cycles after entering FETCH. Minimum 3 cycles per instruction at out_ready=1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect has priority over every other event except reset. In every case pc <= redirect_pc and out_valid=0 in the next cycle. Next state:
  - FETCH, gnt=0: FETCH. The request is withdrawn; next cycle requests the new address.
  - FETCH, gnt=1: DROP.
  - WAIT, rvalid=0: DROP.
  - WAIT, rvalid=1: FETCH. Data is discarded.
  - HOLD: FETCH. The held instruction is discarded even if out_ready=1 in the same cycle, and no pc+4 occurs.
  - DROP, rvalid=0: stay in DROP. pc is still updated.
  - DROP, rvalid=1: FETCH.
- A misaligned redirect_pc is not corrected. It yields an out_adel presentation with out_pc=redirect_pc.
- Reset asserted mid-operation (any state) returns to the reset values. Any rvalid arriving after reset is ignored, because the block is in FETCH and not expecting data. The memory side is reset by the same signal.

Decomposition:
- Shared defines file: IFU_SEL_* select encodings (existing), FSM state encodings (IFU_ST_FETCH/WAIT/HOLD/DROP, 2 bits), RESET_PC default.
- No sub-module: one FSM plus PC and output registers, with PC+4 inline.

Test Plan:
- Reset then free run:
  - Stimulus: gnt=1 always, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_A5A5, out_ready=1.
  - Required: out_pc sequence 3000, 3004, 3008, …, each out_inst matching, 3 cycles per instruction.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles in HOLD with pc=3004.
  - Required: out_valid, out_pc, out_inst stable; no imem_req; pc advances to 3008 only after out_ready=1.
- Redirect in WAIT:
  - Stimulus: redirect_pc=0000_4000 with rvalid arriving 2 cycles later carrying 0xDEADBEEF.
  - Required: 0xDEADBEEF never presented; next imem_addr=4000; out_pc=4000.
- Redirect coincident with out_ready in HOLD:
  - Required: held instruction dropped, pc=redirect_pc, no PC+4 applied.
- Misaligned redirect:
  - Stimulus: redirect_pc=0000_3002.
  - Required: no imem_req; out_valid with out_adel=1, out_inst=0, out_pc=3002.
- Wrap and reset mid-fetch:
  - Stimulus: pc=FFFF_FFFC, accepted.
  - Required: next imem_addr=0000_0000.
  - Stimulus: reset asserted in WAIT.
  - Required: next cycle state FETCH, out_valid=0, pc=RESET_PC.
